gcd_job_sequencer: RTL and testbench

GCD_JOB_SEQUENCER -- requirements
Module: gcd_job_sequencer

---
 rtl/gcd_pkg.sv | 31 +++
 rtl/gcd_job_sequencer.sv | 173 +++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// gcd_pkg : CSR word map of the GCD calculator and sequencer states
// Revision: 1.0
// ------------------------------------------------------------------
package gcd_pkg;

  localparam logic [2:0] GCD_STATUS = 3'd0;
  localparam logic [2:0] GCD_A_LO   = 3'd1;
  localparam logic [2:0] GCD_A_HI   = 3'd2;
  localparam logic [2:0] GCD_B_LO   = 3'd3;
  localparam logic [2:0] GCD_B_HI   = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_ALO    = 4'd1,
    ST_WR_AHI    = 4'd2,
    ST_WR_BLO    = 4'd3,
    ST_WR_BHI    = 4'd4,
    ST_GAP       = 4'd5,
    ST_POLL      = 4'd6,
    ST_POLL_CHK  = 4'd7,
    ST_RD_LO     = 4'd8,
    ST_RD_LO_CAP = 4'd9,
    ST_RD_HI     = 4'd10,
    ST_RD_HI_CAP = 4'd11,
    ST_OUT       = 4'd12
  } gcd_state_e;

endpackage
`default_nettype wire

// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// gcd_job_sequencer : streams operand pairs through a CSR-mapped GCD
//                     calculator and returns gcd(A,B) on a result stream
// Revision: 1.0
// ------------------------------------------------------------------
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [2:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;
  localparam gcd_state_e WAIT_ST = (POLL_GAP > 0) ? ST_GAP : ST_POLL;

  gcd_state_e       state_q, state_d;
  logic [63:0]      a_q, a_d, b_q, b_d;
  logic [63:0]      out_data_q, out_data_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] job_count_q, job_count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             avm_read_q, avm_read_d;
  logic             avm_write_q, avm_write_d;
  logic [2:0]       avm_address_q, avm_address_d;
  logic [31:0]      avm_writedata_q, avm_writedata_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    gap_d       = gap_q;
    job_count_d = job_count_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d = in_data[63:0];
          b_d = in_data[127:64];
          // A zero operand needs no calculator: gcd(x,0)=x, gcd(0,0)=0
          if ((in_data[63:0] == 64'd0) || (in_data[127:64] == 64'd0)) begin
            out_data_d = in_data[63:0] | in_data[127:64];
            state_d    = ST_OUT;
          end else begin
            state_d = ST_WR_ALO;
          end
        end
      end
      ST_WR_ALO: state_d = ST_WR_AHI;
      ST_WR_AHI: state_d = ST_WR_BLO;
      ST_WR_BLO: state_d = ST_WR_BHI;
      ST_WR_BHI: begin
        state_d = WAIT_ST;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_POLL;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      ST_POLL: state_d = ST_POLL_CHK;
      ST_POLL_CHK: begin
        if (avm_readdata != 32'd0) begin
          state_d = WAIT_ST;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = ST_RD_LO;
        end
      end
      ST_RD_LO: state_d = ST_RD_LO_CAP;
      ST_RD_LO_CAP: begin
        out_data_d[31:0] = avm_readdata;
        state_d          = ST_RD_HI;
      end
      ST_RD_HI: state_d = ST_RD_HI_CAP;
      ST_RD_HI_CAP: begin
        out_data_d[63:32] = avm_readdata;
        state_d           = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          job_count_d = job_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    in_ready_d      = (state_d == ST_IDLE);
    out_valid_d     = (state_d == ST_OUT);
    busy_d          = (state_d != ST_IDLE);
    avm_read_d      = 1'b0;
    avm_write_d     = 1'b0;
    avm_address_d   = GCD_STATUS;
    avm_writedata_d = 32'd0;
    case (state_d)
      ST_WR_ALO: begin avm_write_d = 1'b1; avm_address_d = GCD_A_LO; avm_writedata_d = a_d[31:0];  end
      ST_WR_AHI: begin avm_write_d = 1'b1; avm_address_d = GCD_A_HI; avm_writedata_d = a_d[63:32]; end
      ST_WR_BLO: begin avm_write_d = 1'b1; avm_address_d = GCD_B_LO; avm_writedata_d = b_d[31:0];  end
      ST_WR_BHI: begin avm_write_d = 1'b1; avm_address_d = GCD_B_HI; avm_writedata_d = b_d[63:32]; end
      ST_POLL:   begin avm_read_d  = 1'b1; avm_address_d = GCD_STATUS; end
      ST_RD_LO:  begin avm_read_d  = 1'b1; avm_address_d = GCD_A_LO;   end
      ST_RD_HI:  begin avm_read_d  = 1'b1; avm_address_d = GCD_A_HI;   end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      a_q             <= 64'd0;
      b_q             <= 64'd0;
      out_data_q      <= 64'd0;
      gap_q           <= '0;
      job_count_q     <= '0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= 3'd0;
      avm_writedata_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      out_data_q      <= out_data_d;
      gap_q           <= gap_d;
      job_count_q     <= job_count_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign busy          = busy_q;
  assign job_count     = job_count_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_gcd_job_sequencer : two sequencers (POLL_GAP 4 and 0) on a model
//                        GCD calculator, results checked by scoreboard
// Revision: 1.0
// ------------------------------------------------------------------
module tb_gcd_job_sequencer;

  logic        clock;
  logic        reset_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [127:0] in_data   [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [63:0] out_data   [2];
  logic [2:0]  addr       [2];
  logic        rd         [2];
  logic        wr         [2];
  logic [31:0] wdata      [2];
  logic [31:0] rdata      [2];
  logic        busy       [2];
  logic [31:0] jc         [2];

  int total = 0;
  int bad   = 0;
  int sent  [2];
  int ready_mode = 0;

  logic [63:0] expq0[$];
  logic [63:0] expq1[$];
  logic [34:0] wlog[$];

  logic [31:0] sreg     [2][5];
  logic [63:0] sres     [2];
  int          busy_cnt [2];
  int          pulses   [2];
  logic [31:0] last_hi  [2];

  gcd_job_sequencer dut0 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_write(wr[0]),
    .avm_writedata(wdata[0]), .avm_readdata(rdata[0]),
    .busy(busy[0]), .job_count(jc[0])
  );

  gcd_job_sequencer #(.POLL_GAP(0)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_write(wr[1]),
    .avm_writedata(wdata[1]), .avm_readdata(rdata[1]),
    .busy(busy[1]), .job_count(jc[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [63:0] gcd64(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] a = x;
    logic [63:0] b = y;
    logic [63:0] t;
    while (b != 64'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural GCD calculator: status reads nonzero for a random time after start
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int u = 0; u < 2; u++) begin
        busy_cnt[u] <= 0;
        rdata[u]    <= 32'd0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (wr[u] || rd[u]) pulses[u] <= pulses[u] + 1;
        if (wr[u] && addr[u] == 3'd4) begin
          sres[u]     <= gcd64({sreg[u][2], sreg[u][1]}, {wdata[u], sreg[u][3]});
          busy_cnt[u] <= int'($urandom_range(0, 5));
        end else if (busy_cnt[u] > 0) begin
          busy_cnt[u] <= busy_cnt[u] - 1;
        end
        if (wr[u] && addr[u] <= 3'd4) sreg[u][addr[u]] <= wdata[u];
        if (wr[u] && u == 0) wlog.push_back({addr[u], wdata[u]});
        if (rd[u]) begin
          case (addr[u])
            3'd0:    rdata[u] <= (busy_cnt[u] != 0) ? 32'd1 : 32'd0;
            3'd1:    rdata[u] <= sres[u][31:0];
            3'd2:    begin rdata[u] <= sres[u][63:32]; last_hi[u] <= sres[u][63:32]; end
            default: rdata[u] <= 32'd0;
          endcase
        end
      end
    end
  end

  // Result monitor / scoreboard
  always @(negedge clock) begin
    logic [63:0] e;
    if (reset_n) begin
      for (int u = 0; u < 2; u++) begin
        if (out_valid[u] && out_ready[u]) begin
          if ((u == 0 ? expq0.size() : expq1.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result u%0d: got %0h expected none", u, out_data[u]);
          end else begin
            e = (u == 0) ? expq0.pop_front() : expq1.pop_front();
            chk($sformatf("result_u%0d", u), out_data[u], e);
          end
        end
      end
    end
  end

  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready[0] = 1'b1;
        1:       out_ready[0] = 1'b0;
        default: out_ready[0] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input int u, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(posedge clock);
    #1;
    in_valid[u] = 1'b1;
    in_data[u]  = {b, a};
    @(negedge clock);
    while (!in_ready[u] && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL accept_timeout u%0d: got in_ready=0 expected 1", u);
    end
    @(posedge clock);
    if (u == 0) expq0.push_back(gcd64(a, b));
    else        expq1.push_back(gcd64(a, b));
    sent[u]++;
    #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (((u == 0 ? expq0.size() : expq1.size()) != 0 || out_valid[u]) && n < 3000);
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL done_timeout u%0d: got pending result expected none", u);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid[0]), 0);
    chk({tag, "_out_data"},  out_data[0], 0);
    chk({tag, "_in_ready"},  64'(in_ready[0]), 0);
    chk({tag, "_avm_rd_wr"}, 64'({rd[0], wr[0]}), 0);
    chk({tag, "_avm_addr"},  64'(addr[0]), 0);
    chk({tag, "_avm_wdata"}, 64'(wdata[0]), 0);
    chk({tag, "_busy"},      64'(busy[0]), 0);
    chk({tag, "_job_count"}, 64'(jc[0]), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, p, kind;
    logic [63:0] a, b, g, snap_d;
    logic [31:0] snap_c;
    logic stable;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      in_data[u]  = '0;
      sent[u]     = 0;
      pulses[u]   = 0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("in_ready_after_reset", 64'(in_ready[0]), 1);

    // 48,18: CSR write sequence and first completion
    wlog.delete();
    send(0, 64'd48, 64'd18);
    wait_done(0);
    chk("wlog_len", 64'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      chk("wr0", 64'(wlog[0]), {29'd0, 3'd1, 32'd48});
      chk("wr1", 64'(wlog[1]), {29'd0, 3'd2, 32'd0});
      chk("wr2", 64'(wlog[2]), {29'd0, 3'd3, 32'd18});
      chk("wr3", 64'(wlog[3]), {29'd0, 3'd4, 32'd0});
    end
    chk("job_count_1", 64'(jc[0]), 1);

    // Zero operand short-cut
    p = pulses[0];
    send(0, 64'd0, 64'd35);
    n = 0;
    while (!out_valid[0] && n < 5) begin
      @(negedge clock);
      n++;
    end
    chk("zero_job_latency_ok", 64'(n < 2), 1);
    wait_done(0);
    chk("zero_job_csr_pulses", 64'(pulses[0] - p), 0);

    // Result spanning the high word
    send(0, 64'd3 << 40, 64'd5 << 40);
    wait_done(0);
    chk("hi_word_read", 64'(last_hi[0]), 64'h100);

    // Output back-pressure
    ready_mode = 1;
    send(0, 64'd100, 64'd75);
    n = 0;
    while (!out_valid[0] && n < 500) begin
      @(negedge clock);
      n++;
    end
    snap_d = out_data[0];
    snap_c = jc[0];
    stable = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (!out_valid[0] || out_data[0] !== snap_d || in_ready[0] || jc[0] !== snap_c) stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 1);
    chk("stall_data", snap_d, 64'd25);
    ready_mode = 0;
    wait_done(0);
    chk("stall_count_after", 64'(jc[0]), 64'(snap_c) + 1);

    // Randomized jobs with random output back-pressure
    ready_mode = 2;
    repeat (25) begin
      kind = $urandom_range(0, 3);
      g = 64'($urandom_range(1, 5000));
      case (kind)
        0: begin a = {$urandom, $urandom}; b = 64'd0; if ($urandom_range(0, 1) == 1) begin b = a; a = 64'd0; end end
        1: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        2: begin a = g * 64'($urandom_range(1, 1000)); b = g * 64'($urandom_range(1, 1000)); end
        default: begin a = 64'($urandom | 1) << $urandom_range(0, 31); b = 64'($urandom | 1) << $urandom_range(0, 31); end
      endcase
      send(0, a, b);
      wait_done(0);
    end
    ready_mode = 0;
    chk("job_count_random", 64'(jc[0]), 64'(sent[0]));

    // Reset during polling abandons the job
    send(0, 64'd1000, 64'd750);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(rd[0] && addr[0] == 3'd0) && n < 500);
    chk("poll_seen", 64'(rd[0] && addr[0] == 3'd0), 1);
    #2;
    reset_n = 1'b0;
    #1;
    expq0.delete();
    sent[0] = 0;
    check_reset_outputs("midreset");
    p = pulses[0];
    repeat (3) @(negedge clock);
    chk("midreset_no_csr", 64'(pulses[0] - p), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("in_ready_after_midreset", 64'(in_ready[0]), 1);
    send(0, 64'd7, 64'd21);
    wait_done(0);
    chk("job_count_after_midreset", 64'(jc[0]), 1);

    // Back-to-back jobs with POLL_GAP=0
    send(1, 64'd12, 64'd8);
    send(1, 64'd9, 64'd6);
    send(1, 64'd17, 64'd5);
    wait_done(1);
    chk("job_count_gap0", 64'(jc[1]), 3);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
